// File: rtl/vip_line_buffer_ctrl_if.sv
// vip_line_buffer_ctrl_if: pixel stream in, line-buffer RAM control and status out
interface vip_line_buffer_ctrl_if #(
    parameter int COL_W = 10,
    parameter int ROW_W = 10
);
    logic             per_frame_vsync;
    logic             per_frame_href;
    logic             per_frame_clken;
    logic             ram_wr_en;
    logic             ram_wr_bank;
    logic [COL_W-1:0] ram_addr;
    logic             ram_rd_en;
    logic [COL_W-1:0] col_cnt;
    logic [ROW_W-1:0] row_cnt;
    logic             window_valid;
    logic             frame_done;
    logic             err_long_line;
    logic             err_short_line;
    logic             err_early_vsync;

    modport slave (
        input  per_frame_vsync, per_frame_href, per_frame_clken,
        output ram_wr_en, ram_wr_bank, ram_addr, ram_rd_en, col_cnt, row_cnt,
               window_valid, frame_done, err_long_line, err_short_line, err_early_vsync
    );

    modport master (
        output per_frame_vsync, per_frame_href, per_frame_clken,
        input  ram_wr_en, ram_wr_bank, ram_addr, ram_rd_en, col_cnt, row_cnt,
               window_valid, frame_done, err_long_line, err_short_line, err_early_vsync
    );
endinterface

// File: rtl/vip_line_buffer_ctrl.sv
// vip_line_buffer_ctrl: column/row sequencer for a two-bank line-buffer ring feeding a 3x3 window
module vip_line_buffer_ctrl #(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    parameter int COL_W      = 10,
    parameter int ROW_W      = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    vip_line_buffer_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, WAIT_LINE, IN_LINE, FRAME_END} state_t;

    // One extra bit so the column can reach IMG_WIDTH even when IMG_WIDTH == 2^COL_W
    localparam logic [COL_W:0]   COL_LIM  = (COL_W+1)'(IMG_WIDTH);
    localparam logic [COL_W:0]   COL_ONE  = (COL_W+1)'(1);
    localparam logic [COL_W:0]   COL_TWO  = (COL_W+1)'(2);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);
    localparam logic [ROW_W-1:0] ROW_ONE  = ROW_W'(1);
    localparam logic [ROW_W-1:0] ROW_TWO  = ROW_W'(2);

    state_t           state_q, state_d;
    logic             vs_q, hr_q;
    logic [COL_W:0]   col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic             bank_q, bank_d;
    logic             strobe_q, strobe_d;
    logic [COL_W-1:0] ccnt_q, ccnt_d;
    logic [ROW_W-1:0] rcnt_q, rcnt_d;
    logic             wv_q, wv_d;
    logic             fd_q, fd_d;
    logic             el_q, el_d;
    logic             es_q, es_d;
    logic             ev_q, ev_d;

    logic           vs_rise, hr_rise, hr_fall, pix;
    logic [COL_W:0] cur_col;

    assign vs_rise = bus.per_frame_vsync & ~vs_q;
    assign hr_rise = bus.per_frame_href & ~hr_q;
    assign hr_fall = ~bus.per_frame_href & hr_q;
    // A pixel arriving with the href rise is column 0 of the new line
    assign cur_col = (state_q == IN_LINE) ? col_q : '0;
    assign pix     = ~vs_rise & bus.per_frame_href & bus.per_frame_clken &
                     ((state_q == IN_LINE) | ((state_q == WAIT_LINE) & hr_rise));

    // Next-state, counters and registered outputs; vsync rise overrides everything
    always_comb begin
        state_d  = state_q;
        col_d    = col_q;
        row_d    = row_q;
        bank_d   = bank_q;
        strobe_d = 1'b0;
        ccnt_d   = ccnt_q;
        rcnt_d   = rcnt_q;
        wv_d     = 1'b0;
        fd_d     = 1'b0;
        el_d     = el_q;
        es_d     = es_q;
        ev_d     = ev_q;
        if (vs_rise) begin
            state_d = WAIT_LINE;
            col_d   = '0;
            row_d   = '0;
            bank_d  = 1'b0;
            ccnt_d  = '0;
            rcnt_d  = '0;
            el_d    = 1'b0;
            es_d    = 1'b0;
            ev_d    = (state_q == WAIT_LINE) || (state_q == IN_LINE);
        end else begin
            case (state_q)
                WAIT_LINE: begin
                    if (hr_rise) begin
                        state_d = IN_LINE;
                        col_d   = '0;
                    end
                end
                IN_LINE: begin
                    if (hr_fall) begin
                        es_d   = es_q | (col_q < COL_LIM);
                        bank_d = ~bank_q;
                        if (row_q == ROW_LAST) begin
                            state_d = FRAME_END;
                            fd_d    = 1'b1;
                        end else begin
                            state_d = WAIT_LINE;
                            row_d   = row_q + ROW_ONE;
                        end
                    end
                end
                FRAME_END: state_d = IDLE;
                default:   state_d = IDLE;
            endcase
            if (pix) begin
                if (cur_col < COL_LIM) begin
                    strobe_d = 1'b1;
                    ccnt_d   = cur_col[COL_W-1:0];
                    rcnt_d   = row_q;
                    wv_d     = (row_q >= ROW_TWO) && (cur_col >= COL_TWO);
                    col_d    = cur_col + COL_ONE;
                end else begin
                    el_d = 1'b1;
                end
            end
        end
    end

    // State, edge detectors and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            vs_q     <= 1'b0;
            hr_q     <= 1'b0;
            col_q    <= '0;
            row_q    <= '0;
            bank_q   <= 1'b0;
            strobe_q <= 1'b0;
            ccnt_q   <= '0;
            rcnt_q   <= '0;
            wv_q     <= 1'b0;
            fd_q     <= 1'b0;
            el_q     <= 1'b0;
            es_q     <= 1'b0;
            ev_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            vs_q     <= bus.per_frame_vsync;
            hr_q     <= bus.per_frame_href;
            col_q    <= col_d;
            row_q    <= row_d;
            bank_q   <= bank_d;
            strobe_q <= strobe_d;
            ccnt_q   <= ccnt_d;
            rcnt_q   <= rcnt_d;
            wv_q     <= wv_d;
            fd_q     <= fd_d;
            el_q     <= el_d;
            es_q     <= es_d;
            ev_q     <= ev_d;
        end
    end

    assign bus.ram_wr_en       = strobe_q;
    assign bus.ram_rd_en       = strobe_q;
    assign bus.ram_wr_bank     = bank_q;
    assign bus.ram_addr        = ccnt_q;
    assign bus.col_cnt         = ccnt_q;
    assign bus.row_cnt         = rcnt_q;
    assign bus.window_valid    = wv_q;
    assign bus.frame_done      = fd_q;
    assign bus.err_long_line   = el_q;
    assign bus.err_short_line  = es_q;
    assign bus.err_early_vsync = ev_q;
endmodule

// File: tb/tb_vip_line_buffer_ctrl.sv
// tb_vip_line_buffer_ctrl: randomized frames checked against a frame-level expectation model
module tb_vip_line_buffer_ctrl;
    localparam int W  = 8;
    localparam int H  = 4;
    localparam int CW = 3;
    localparam int RW = 2;

    typedef struct {
        int t;
        int row;
        int col;
    } pix_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    pix_t exp_q[$];
    int   fd_q[$];
    bit   in_frame;
    int   line_idx;
    bit   exp_long, exp_short, exp_early;

    always #5 clk = ~clk;

    vip_line_buffer_ctrl_if #(.COL_W(CW), .ROW_W(RW)) bus ();

    vip_line_buffer_ctrl #(
        .IMG_WIDTH(W), .IMG_HEIGHT(H), .COL_W(CW), .ROW_W(RW)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input longint obs, input longint exp);
        n_cmp++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Every strobe must match the next expected pixel, in order and on its cycle
    always @(negedge clk) begin
        pix_t e;
        if (rst_n) begin
            if (bus.ram_wr_en) begin
                if (exp_q.size() == 0) begin
                    check("wr_unexpected", bus.ram_wr_en, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("wr_cycle", cyc, e.t);
                    check("rd_en", bus.ram_rd_en, 1);
                    check("ram_addr", bus.ram_addr, e.col);
                    check("col_cnt", bus.col_cnt, e.col);
                    check("row_cnt", bus.row_cnt, e.row);
                    check("wr_bank", bus.ram_wr_bank, e.row % 2);
                    check("window_valid", bus.window_valid, (e.row >= 2 && e.col >= 2) ? 1 : 0);
                end
            end else begin
                check("rd_en_idle", bus.ram_rd_en, 0);
                check("wv_idle", bus.window_valid, 0);
            end
            if (bus.frame_done) begin
                if (fd_q.size() == 0) check("fd_unexpected", bus.frame_done, 0);
                else check("fd_cycle", cyc, fd_q.pop_front());
            end
        end
    end

    task automatic step(input bit vs, input bit hr, input bit ck);
        @(posedge clk);
        #1;
        bus.per_frame_vsync = vs;
        bus.per_frame_href  = hr;
        bus.per_frame_clken = ck;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_wr_en"}, bus.ram_wr_en, 0);
        check({tag, "_rd_en"}, bus.ram_rd_en, 0);
        check({tag, "_bank"}, bus.ram_wr_bank, 0);
        check({tag, "_addr"}, bus.ram_addr, 0);
        check({tag, "_col"}, bus.col_cnt, 0);
        check({tag, "_row"}, bus.row_cnt, 0);
        check({tag, "_wv"}, bus.window_valid, 0);
        check({tag, "_fd"}, bus.frame_done, 0);
        check({tag, "_el"}, bus.err_long_line, 0);
        check({tag, "_es"}, bus.err_short_line, 0);
        check({tag, "_ev"}, bus.err_early_vsync, 0);
    endtask

    task automatic vsync_pulse(input bit keep_href);
        step(1, keep_href, 0);
        exp_early = in_frame;
        exp_long  = 0;
        exp_short = 0;
        in_frame  = 1;
        line_idx  = 0;
        step(1, keep_href, 0);
        step(0, 0, 1'($urandom % 2));
    endtask

    // mode 0: continuous clken, 1: alternating, 2: random
    task automatic drive_pixels(input int npix, input int mode);
        int   k  = 0;
        bit   ph = 1;
        bit   c;
        pix_t p;
        while (k < npix) begin
            c  = (mode == 0) ? 1'b1 : (mode == 1) ? ph : 1'($urandom % 2);
            ph = ~ph;
            step(0, 1, c);
            if (c) begin
                if (in_frame && k < W) begin
                    p.t   = cyc + 1;
                    p.row = line_idx;
                    p.col = k;
                    exp_q.push_back(p);
                end
                k++;
            end
        end
    endtask

    task automatic drive_line(input int npix, input int mode);
        drive_pixels(npix, mode);
        step(0, 0, 1'($urandom % 2));
        if (in_frame) begin
            if (npix < W) exp_short = 1;
            if (npix > W) exp_long = 1;
            if (line_idx == H - 1) begin
                fd_q.push_back(cyc + 1);
                in_frame = 0;
            end
            line_idx++;
        end
        repeat (1 + $urandom % 3) step(0, 0, 1'($urandom % 2));
    endtask

    task automatic settle();
        repeat (4) step(0, 0, 0);
        check("wr_missing", exp_q.size(), 0);
        check("fd_missing", fd_q.size(), 0);
        check("err_long", bus.err_long_line, exp_long);
        check("err_short", bus.err_short_line, exp_short);
        check("err_early", bus.err_early_vsync, exp_early);
        exp_q.delete();
        fd_q.delete();
    endtask

    task automatic frame(input int bad_line, input int bad_len, input int mode);
        vsync_pulse(0);
        for (int l = 0; l < H; l++) drive_line((l == bad_line) ? bad_len : W, mode);
        settle();
    endtask

    initial begin
        bus.per_frame_vsync = 0;
        bus.per_frame_href  = 0;
        bus.per_frame_clken = 0;
        in_frame = 0;
        line_idx = 0;
        exp_long = 0;
        exp_short = 0;
        exp_early = 0;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        rst_n = 1;

        frame(-1, 0, 0);
        frame(-1, 0, 1);
        frame(1, 10, 0);
        frame(2, 5, 1);

        vsync_pulse(0);
        drive_line(W, 0);
        drive_line(W, 2);
        drive_pixels(3, 0);
        vsync_pulse(1);
        for (int l = 0; l < H; l++) drive_line(W, 0);
        settle();

        vsync_pulse(0);
        drive_line(W, 0);
        drive_pixels(3, 0);
        step(0, 1, 0);
        @(posedge clk);
        #1;
        rst_n = 0;
        #1;
        check_zero("midline_rst");
        exp_q.delete();
        fd_q.delete();
        in_frame = 0;
        exp_long = 0;
        exp_short = 0;
        exp_early = 0;
        step(0, 1, 1);
        step(0, 1, 1);
        step(0, 0, 0);
        rst_n = 1;
        drive_line(W, 0);
        drive_line(W, 2);
        settle();
        frame(-1, 0, 2);

        for (int i = 0; i < 6; i++) frame($urandom_range(0, H), $urandom_range(W - 3, W + 3), 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/vip_line_buffer_ctrl.md
Name: vip_line_buffer_ctrl

Overview:
Sequencer for the two-line buffer behind the 3x3 window generator. It tracks the pixel column and row from the per-frame sync/enable stream and issues write enables, addresses and bank selects to two single-line RAMs arranged as a ring. It flags when a full 3x3 window is valid and reports frame completion and malformed-frame errors. It sits between the sensor/ISP pixel stream and the matrix generator, replacing its free-running shift RAM with explicit addressed storage.

Parameters:
IMG_WIDTH, 640, active pixels per line.
IMG_HEIGHT, 480, active lines per frame.
COL_W, 10, column counter and address width; must satisfy 2^COL_W >= IMG_WIDTH.
ROW_W, 10, row counter width; must satisfy 2^ROW_W >= IMG_HEIGHT.

Ports:
clk  in  1  pixel clock
rst_n  in  1  asynchronous active-low reset
per_frame_vsync  in  1  frame sync, active high
per_frame_href  in  1  line valid, active high
per_frame_clken  in  1  pixel qualifier, valid only while href=1
ram_wr_en  out  1  write strobe for the bank selected by ram_wr_bank
ram_wr_bank  out  1  bank receiving current line (= bank holding row N-2)
ram_addr  out  COL_W  shared read/write address (= column)
ram_rd_en  out  1  read strobe, both banks
col_cnt  out  COL_W  column of the pixel presented this cycle
row_cnt  out  ROW_W  row of the pixel presented this cycle
window_valid  out  1  3x3 window centred at (row-1, col-1) is complete
frame_done  out  1  one-cycle pulse after the last pixel of the last line
err_long_line  out  1  sticky: more than IMG_WIDTH clken in one line
err_short_line  out  1  sticky: href fell with fewer than IMG_WIDTH pixels
err_early_vsync  out  1  sticky: vsync rose before frame completion

Behaviour:
- Reset: state IDLE; all outputs 0; ram_wr_bank 0; internal edge detectors 0.
- Edges are detected from 1-cycle registered copies of vsync and href. Every output is registered. There is one cycle of latency from a sampled input to the corresponding output.
- States:
  - IDLE: waits for a vsync rising edge, then clears the row counter, the column counter and all err_* flags, sets ram_wr_bank=0, and goes to WAIT_LINE.
  - WAIT_LINE: on an href rising edge, clears the column counter and goes to IN_LINE. A clken seen in the same cycle as the href rise counts as pixel 0.
  - IN_LINE, per pixel (href=1 and clken=1) with column < IMG_WIDTH:
    - next cycle: ram_rd_en=1, ram_wr_en=1, ram_addr=column, col_cnt=column, row_cnt=row;
    - window_valid=1 iff row>=2 and column>=2;
    - column increments.
  - IN_LINE, pixel with column == IMG_WIDTH: no strobes; err_long_line is set.
  - IN_LINE, href falling edge: if column < IMG_WIDTH, set err_short_line. Then toggle ram_wr_bank. If row == IMG_HEIGHT-1, go to FRAME_END; otherwise increment row and go to WAIT_LINE.
  - FRAME_END: frame_done=1 for exactly one cycle, then IDLE.
- Bank ring: the RAMs are read-before-write. Reading bank ~ram_wr_bank gives row N-1. Reading bank ram_wr_bank at the same address gives row N-2, and that address is then overwritten with row N. No data is needed for rows 0 and 1; window_valid stays 0 there.
- clken with href=0 is ignored in every state.
- vsync rising edge in WAIT_LINE or IN_LINE: set err_early_vsync, restart as for IDLE (counters cleared, bank 0, go to WAIT_LINE), and suppress frame_done. Because the restart clears the err_* flags, err_early_vsync is set after the clear and stays visible.
- Strobes are 0 outside IN_LINE pixel cycles. col_cnt and row_cnt hold their last values between pixels.
- Async reset mid-line forces IDLE in the same cycle. After release the block ignores all traffic until the next vsync rising edge.

Test Plan:
1. IMG_WIDTH=8, IMG_HEIGHT=4, continuous clken, clean frame -> 32 ram_wr_en pulses. ram_addr cycles 0..7. ram_wr_bank sequence is 0,1,0,1 per line. window_valid is asserted on 12 pixels (rows 2-3, cols 2-7). frame_done pulses once, 1 cycle after the last href fall. No err_* flags set.
2. Same frame with clken toggling every other cycle -> identical addresses and count. Strobes appear only 1 cycle after clken=1 cycles.
3. Line 1 carries 10 clken -> err_long_line=1; only 8 writes on that line; the remaining lines are unaffected.
4. Line 2 carries 5 pixels -> err_short_line=1; row still advances; frame_done still pulses.
5. vsync rises during row 2 -> err_early_vsync=1; row_cnt and col_cnt restart at 0 on the next line; no frame_done for the aborted frame.
6. rst_n pulsed low mid-line -> all outputs 0 immediately. Subsequent href pulses with no new vsync produce no strobes.
